// File: rtl/rx_bit_sampler_pkg.sv
// rx_bit_sampler_pkg: rate divider mapping and receive FSM states shared by the serial link blocks
package rx_bit_sampler_pkg;
  localparam logic [7:0] DIV_MAX = 8'd64;
  typedef enum logic [1:0] {IDLE, HUNT, TRACK} rx_state_e;
  function automatic logic [7:0] rate_div(input logic [2:0] sel);
    return (sel <= 3'd5) ? (DIV_MAX >> sel) : DIV_MAX;
  endfunction
endpackage

// File: rtl/rx_bit_sampler_sync2.sv
// rx_sync2: two-flop synchronizer with a selectable reset level
module rx_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic ff1;
  always_ff @(posedge clk) begin
    if (!rst_n) {ff1, q} <= {2{RST_VAL}};
    else        {ff1, q} <= {d, ff1};
  end
endmodule

// File: rtl/rx_bit_sampler.sv
// rx_bit_sampler: recovers bit phase from line edges and emits mid-bit samples with lock status
module rx_bit_sampler
  import rx_bit_sampler_pkg::*;
#(
  parameter int   CLK_HZ     = 130_000_000,
  parameter int   LOCK_EDGES = 4,
  parameter logic RX_IDLE    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] rate_sel,
  input  logic       enable,
  input  logic       rx_in,
  output logic       bit_tick,
  output logic       bit_data,
  output logic       locked,
  output logic       phase_err
);
  localparam logic [3:0] LE = 4'(LOCK_EDGES);
  if (LOCK_EDGES < 1 || LOCK_EDGES > 15 || CLK_HZ <= 0) begin : g_bad_param
    $error("rx_bit_sampler: parameter out of range");
  end
  rx_state_e  state, state_n;
  logic [7:0] cnt, cnt_n, div;
  logic [3:0] good, good_n;
  logic       rx_s, rx_d, rx_edge, on_time;
  logic       locked_n, tick_n, data_n, perr_n;
  rx_sync2 #(.RST_VAL(RX_IDLE)) u_sync (.clk(clk), .rst_n(rst_n), .d(rx_in), .q(rx_s));
  always_ff @(posedge clk) begin
    if (!rst_n) rx_d <= RX_IDLE;
    else        rx_d <= rx_s;
  end
  assign div     = rate_div(rate_sel);
  assign rx_edge = rx_s ^ rx_d;
  // edge counts as on-time within one cycle of the expected phase 0
  assign on_time = (div == 8'd2) || (cnt == div - 8'd1) || (cnt <= 8'd1);
  always_comb begin
    state_n  = state;
    cnt_n    = 8'd0;
    good_n   = good;
    locked_n = locked;
    tick_n   = 1'b0;
    data_n   = bit_data;
    perr_n   = 1'b0;
    if (!enable) begin
      state_n  = IDLE;
      good_n   = 4'd0;
      locked_n = 1'b0;
    end else if (state == IDLE) begin
      state_n = HUNT;
    end else if (state == HUNT) begin
      if (rx_edge) begin
        state_n  = TRACK;
        cnt_n    = 8'd1;
        good_n   = 4'd1;
        locked_n = (LE == 4'd1);
      end
    end else if (rx_edge) begin
      cnt_n    = 8'd1;
      good_n   = on_time ? ((good >= LE) ? LE : good + 4'd1) : 4'd1;
      locked_n = on_time && (locked || good_n == LE);
      perr_n   = !on_time;
    end else begin
      // wrap also covers a counter stranded above a newly smaller divider
      cnt_n  = (cnt >= div - 8'd1) ? 8'd0 : cnt + 8'd1;
      tick_n = (cnt == (div >> 1));
      data_n = tick_n ? rx_s : bit_data;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      good      <= 4'd0;
      locked    <= 1'b0;
      bit_tick  <= 1'b0;
      bit_data  <= 1'b0;
      phase_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      good      <= good_n;
      locked    <= locked_n;
      bit_tick  <= tick_n;
      bit_data  <= data_n;
      phase_err <= perr_n;
    end
  end
endmodule

// File: doc/rx_bit_sampler.md
# rx_bit_sampler

Receive-side bit timing recovery for the serial link. Takes the asynchronous serial input, synchronizes it into `clk`, and recovers the bit phase from data edges using the same `rate_sel` → divider mapping as the transmit side. Emits a one-cycle `bit_tick` with the mid-bit sampled `bit_data`, plus lock and phase-error status, to the downstream deframer.

## Interface
- `CLK_HZ`, default 130_000_000: clock frequency; informational only, no arithmetic depends on it.
- `LOCK_EDGES`, default 4: number of consecutive on-time edges required to assert `locked`. Range 1..15.
- `RX_IDLE`, default 1'b1: line idle level; reset value of the synchronizer flops.
- `clk` input 1: `clk_130M`, the single clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `rate_sel` input 3: rate select. 0→div 64, 1→32, 2→16, 3→8, 4→4, 5→2, 6/7→64.
- `enable` input 1: receive window; 0 holds the block idle.
- `rx_in` input 1: asynchronous serial line.
- `bit_tick` output 1: one-cycle pulse per recovered bit.
- `bit_data` output 1: sampled bit; valid when `bit_tick`=1 and held until the next tick.
- `locked` output 1: phase lock status.
- `phase_err` output 1: one-cycle pulse on an off-time edge.

## Operation
- Synchronizer: `rx_in` → ff1 → ff2 (`rx_s`) → ff3 (`rx_d`). All three reset to `RX_IDLE`. They run regardless of `enable`. `edge` = `rx_s ^ rx_d`.
- Phase counter `cnt` is 8 bits, range 0..div-1. The cycle in which `edge` is true is phase 0, so on an edge `cnt` is loaded with 1 (for div=2, 1 is div-1). Otherwise `cnt` counts up and wraps from div-1 to 0.
- Sample point: when `cnt == div/2` in TRACK, register `bit_tick`<=1 and `bit_data`<=`rx_s`.
- The on-time window is an edge arriving with the current `cnt` in {div-1, 0, 1}. At div=2 every edge is on-time.
- States:
  - IDLE: `enable`=0. Hold `cnt`=0 and `good`=0. All outputs 0 except `bit_data`, which holds. On `enable`=1, go to HUNT.
  - HUNT: `cnt` held at 0, no ticks. On the first `edge`: `cnt`<=1, `good`<=1, go to TRACK. If `LOCK_EDGES`=1, also assert `locked`.
  - TRACK:
    - On-time edge: `good` increments, saturating at `LOCK_EDGES`. `locked`<=1 when `good` reaches `LOCK_EDGES`.
    - Off-time edge: `good`<=1, `locked`<=0, `phase_err` pulses.
    - Both kinds of edge resync `cnt`<=1.
    - With no edges, the block free-runs and ticks once per div cycles.
- `enable` falling in any state returns to IDLE on the next clock and clears `cnt`, `good`, `locked`, `bit_tick` and `phase_err`. No tick is emitted in the cycle after `enable` falls.
- `rate_sel` must be static while `enable`=1. If it changes anyway and `cnt` ≥ new div, `cnt` wraps to 0 on the next clock. No X and no hang.
- `rst_n`=0 at any time overrides everything: state IDLE, all counters 0, outputs 0, synchronizer set to `RX_IDLE`.

## Timing
- Reset values: `bit_tick`=0, `bit_data`=0, `locked`=0, `phase_err`=0.
- Line change captured by ff1 at posedge T:
  - `edge` is true in the cycle after posedge T+1.
  - `cnt`=1 after posedge T+2.
  - `bit_tick` is high after posedge T+2+div/2. At div=16 that is T+10; at div=2 it is T+3.
- `phase_err` is high the cycle after the posedge that registers the off-time edge, which is the same posedge that loads `cnt`<=1.
- `locked` rises on the same posedge that `good` reaches `LOCK_EDGES`.
- Tick spacing with no edges is exactly div cycles.
- An edge and the sample point cannot coincide, because div/2 ∉ {div-1, 0} for div ≥ 4. At div=2 the edge resync takes priority and the sample happens the next cycle.

## Structure
- Shared package:
  - `rate_sel` → div mapping function and its constants, shared by the TX tick generator and this block.
  - State enum IDLE/HUNT/TRACK.
- Sub-module `rx_sync2`: two-flop synchronizer with a reset-value parameter.
- The remaining logic (FSM, phase counter, lock counter) stays flat in `rx_bit_sampler`.

## Test plan
- **Reset/idle:** `rst_n`=0 for 3 clocks with `rx_in` toggling → all outputs 0. With `enable`=0 afterwards → no `bit_tick` for 200 clocks.
- **Acquisition at `rate_sel`=2 (div 16):** alternating bits every 16 clocks, first transition captured at posedge T → first `bit_tick` at T+10, then every 16 clocks. `bit_data` matches the driven pattern. `locked`=1 after the 4th edge.
- **Jitter tolerance:** ±1-clock edge jitter at div 16 → `locked` stays 1, no `phase_err`. A single edge shifted by +4 → one `phase_err` pulse, `locked`=0, relock after 3 further on-time edges.
- **Max rate, `rate_sel`=5 (div 2):** alternating 1010 data → a tick every 2 clocks with correct data, and `phase_err` never asserts.
- **Free-run:** at div 64 send 0xFF00 with long runs → ticks every 64 clocks across the runs, 8 ones then 8 zeros.
- **Abort:** drop `enable` mid-bit at div 8 → the next cycle `bit_tick`=0 and `locked`=0. Re-enable → HUNT, no tick until an edge.
